// File: rtl/div_sched.sv
// div_sched: round-robin shared restoring divider for two requesters
module div_sched #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [W-1:0]   num0,
    input  logic [W-1:0]   den0,
    input  logic           req1,
    input  logic [W-1:0]   num1,
    input  logic [W-1:0]   den1,
    output logic           ack0,
    output logic           ack1,
    output logic           busy,
    output logic           done,
    output logic           res_id,
    output logic [2*W-1:0] led,
    output logic           dz
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   num_q, den_q, rem_q, quot_q;
    logic [CW-1:0]  cnt_q;
    logic           lg_q, gid_q, res_q, dz_q;
    logic [2*W-1:0] led_q;
    logic           gnt, accept, last, ge;
    logic [W:0]     rem_sh;
    logic [W-1:0]   rem_nx, quot_nx;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state: accept on any request, W compute cycles, one result cycle
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? CALC : IDLE) :
                  (state_q == CALC) ? (last ? DONE : CALC) : IDLE;
    end

    // outputs: ack is the first CALC cycle, tagged by the granted requester
    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
        ack0 = (state_q == CALC) && (cnt_q == '0) && !gid_q;
        ack1 = (state_q == CALC) && (cnt_q == '0) && gid_q;
    end

    // arbitration and one restoring shift-subtract step, MSB first
    always_comb begin
        gnt     = (req0 && req1) ? !lg_q : req1;
        accept  = (state_q == IDLE) && (req0 || req1);
        last    = cnt_q == CW'(W - 1);
        rem_sh  = {rem_q, num_q[W-1]};
        ge      = rem_sh >= {1'b0, den_q};
        rem_nx  = ge ? W'(rem_sh - {1'b0, den_q}) : rem_sh[W-1:0];
        quot_nx = {quot_q[W-2:0], ge};
    end

    // operand capture, iteration state and held result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            lg_q   <= 1'b1;
            gid_q  <= 1'b0;
            res_q  <= 1'b0;
            dz_q   <= 1'b0;
            led_q  <= '0;
        end else if (accept) begin
            num_q  <= gnt ? num1 : num0;
            den_q  <= gnt ? den1 : den0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            lg_q   <= gnt;
            gid_q  <= gnt;
        end else if (state_q == CALC) begin
            num_q  <= num_q << 1;
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q + 1'b1;
            if (last) begin
                led_q <= {quot_nx, rem_nx};
                res_q <= gid_q;
                dz_q  <= den_q == '0;
            end
        end
    end

    assign led    = led_q;
    assign res_id = res_q;
    assign dz     = dz_q;
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed vector and sequence checks for div_sched
module tb_div_sched;
    localparam int W = 4;

    logic           clk = 0, rst = 0;
    logic           req0 = 0, req1 = 0;
    logic [W-1:0]   num0 = 0, den0 = 0, num1 = 0, den1 = 0;
    logic           ack0, ack1, busy, done, res_id, dz;
    logic [2*W-1:0] led;

    int checks = 0;
    int errors = 0;

    div_sched #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .num0(num0), .den0(den0),
        .req1(req1), .num1(num1), .den1(den1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
        .res_id(res_id), .led(led), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [3:0] num;
        logic [3:0] den;
        logic [7:0] led;
        logic       dz;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller has requests set during an IDLE cycle; next edge is the accept edge.
    task automatic txn(input logic eid, input logic [7:0] eled, input logic edz, input logic drop);
        @(posedge clk); #1;
        chk("ack0", {7'b0, ack0}, {7'b0, !eid});
        chk("ack1", {7'b0, ack1}, {7'b0, eid});
        chk("busy", {7'b0, busy}, 8'd1);
        if (drop) begin
            req0 = 0; req1 = 0;
            num0 = 4'd3; num1 = 4'd3; den0 = 4'd1; den1 = 4'd1;
        end
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            chk("no_ack_busy", {6'b0, ack1, ack0}, 8'd0);
            if (k < W) begin
                chk("done_early", {7'b0, done}, 8'd0);
            end else begin
                chk("done", {7'b0, done}, 8'd1);
                chk("led", led, eled);
                chk("res_id", {7'b0, res_id}, {7'b0, eid});
                chk("dz", {7'b0, dz}, {7'b0, edz});
            end
        end
    endtask

    task automatic to_idle();
        @(posedge clk); #1;
        chk("idle_busy", {7'b0, busy}, 8'd0);
        chk("idle_done", {7'b0, done}, 8'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ack", {6'b0, ack1, ack0}, 8'd0);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_done", {7'b0, done}, 8'd0);
        chk("rst_dz_id", {6'b0, dz, res_id}, 8'd0);
        chk("rst_led", led, 8'd0);
    endtask

    initial begin
        v[0]  = '{1'b0, 4'd13, 4'd4,  8'h31, 1'b0};
        v[1]  = '{1'b1, 4'd7,  4'd0,  8'hF7, 1'b1};
        v[2]  = '{1'b0, 4'd6,  4'd5,  8'h11, 1'b0};
        v[3]  = '{1'b1, 4'd12, 4'd5,  8'h22, 1'b0};
        v[4]  = '{1'b0, 4'd10, 4'd3,  8'h31, 1'b0};
        v[5]  = '{1'b1, 4'd15, 4'd1,  8'hF0, 1'b0};
        v[6]  = '{1'b0, 4'd9,  4'd3,  8'h30, 1'b0};
        v[7]  = '{1'b1, 4'd0,  4'd7,  8'h00, 1'b0};
        v[8]  = '{1'b0, 4'd15, 4'd15, 8'h10, 1'b0};
        v[9]  = '{1'b1, 4'd0,  4'd0,  8'hF0, 1'b1};
        v[10] = '{1'b0, 4'd14, 4'd3,  8'h42, 1'b0};

        #1 rst = 1;
        #1 chk_reset_outputs();
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            req0 = !v[i].sel; req1 = v[i].sel;
            num0 = v[i].num;  den0 = v[i].den;
            num1 = v[i].num;  den1 = v[i].den;
            txn(v[i].sel, v[i].led, v[i].dz, 1'b1);
            to_idle();
        end

        rst = 1; #1; rst = 0;
        req0 = 1; num0 = 4'd15; den0 = 4'd1;
        req1 = 1; num1 = 4'd9;  den1 = 4'd3;
        txn(1'b0, 8'hF0, 1'b0, 1'b0);
        to_idle();
        txn(1'b1, 8'h30, 1'b0, 1'b1);
        to_idle();

        req0 = 1; num0 = 4'd6; den0 = 4'd5;
        txn(1'b0, 8'h11, 1'b0, 1'b0);
        to_idle();
        txn(1'b0, 8'h11, 1'b0, 1'b0);
        to_idle();
        txn(1'b0, 8'h11, 1'b0, 1'b1);
        to_idle();

        req0 = 1; num0 = 4'd12; den0 = 4'd5;
        @(posedge clk); #1;
        chk("mid_ack0", {7'b0, ack0}, 8'd1);
        req0 = 0;
        @(posedge clk); #1;
        rst = 1; #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", {5'b0, done, ack1, ack0}, 8'd0);
        end
        req1 = 1; num1 = 4'd12; den1 = 4'd5;
        txn(1'b1, 8'h22, 1'b0, 1'b1);
        to_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
